// File: rtl/uart_tx_arb_ctrl.sv
// Two-requester round-robin UART transmitter: start/data/[parity]/stop from an internal baud counter.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_arb_ctrl #(
    parameter int BAUD_MAX  = 10414,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iReq0_valid,
    input  logic [DATA_BITS-1:0] iReq0_data,
    output logic                 oReq0_ready,
    input  logic                 iReq1_valid,
    input  logic [DATA_BITS-1:0] iReq1_data,
    output logic                 oReq1_ready,
    output logic                 oTX,
    output logic                 oBusy,
    output logic                 oGrant,
    output logic                 oFrame_done
);
    localparam int BW = (BAUD_MAX > 0) ? $clog2(BAUD_MAX + 1) : 1;
    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [IW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 grant_q, grant_d;
    logic                 last_q, last_d;
    logic                 tx_q, tx_d;
    logic                 tick;
    logic                 acc0, acc1;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tick = (baud_q == BW'(BAUD_MAX));
    assign acc0 = iReq0_valid & oReq0_ready;
    assign acc1 = iReq1_valid & oReq1_ready;

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        baud_d  = tick ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (acc0 || acc1) begin
                    state_d = S_START;
                    shift_d = acc1 ? iReq1_data : iReq0_data;
                    grant_d = acc1;
                    last_d  = acc1;
`ifdef UART_TX_PARITY_EN
                    par_d   = acc1 ? ^iReq1_data : ^iReq0_data;
`endif
                end
            end
            S_START: if (tick) state_d = S_DATA;
            S_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == IW'(DATA_BITS - 1)) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: if (tick) state_d = S_STOP;
            S_STOP: begin
                if (tick) begin
                    if (bit_q == IW'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line is registered off the next state so the start bit appears the cycle after accept.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // Outputs
    always_comb begin
        oReq0_ready = 1'b0;
        oReq1_ready = 1'b0;
        if (state_q == S_IDLE) begin
            oReq0_ready = iReq0_valid & (~iReq1_valid | last_q);
            oReq1_ready = iReq1_valid & (~iReq0_valid | ~last_q);
        end
        oTX         = tx_q;
        oBusy       = (state_q != S_IDLE);
        oGrant      = grant_q;
        oFrame_done = (state_q == S_STOP) && tick && (bit_q == IW'(STOP_BITS - 1));
    end

endmodule

// File: tb/tb_uart_tx_arb_ctrl.sv
// Scoreboard bench for uart_tx_arb_ctrl: stimulus queues expected frames, a line monitor checks
// every cycle of each serial frame against them.
module tb_uart_tx_arb_ctrl;
    localparam int B  = 3;
    localparam int DB = 8;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int BP = B + 1;
    localparam int FL = (1 + DB + PB + SB) * BP;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic [DB-1:0] d0 = '0, d1 = '0;
    logic          r0, r1, tx, busy, grant, done;

    typedef struct packed {logic g; logic [DB-1:0] d;} exp_t;
    exp_t sb_q[$];

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    bit  started = 1'b0;
    bit  mon_busy = 1'b0;

    uart_tx_arb_ctrl #(.BAUD_MAX(B), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
        .clk(clk), .reset(reset),
        .iReq0_valid(v0), .iReq0_data(d0), .oReq0_ready(r0),
        .iReq1_valid(v1), .iReq1_data(d1), .oReq1_ready(r1),
        .oTX(tx), .oBusy(busy), .oGrant(grant), .oFrame_done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Readies must never be high together
    always @(negedge clk) if (started && (r0 || r1)) chk("one_ready", {31'd0, r0 & r1}, 0);

    // Line monitor
    initial begin : mon
        exp_t e;
        bit   abort;
        int   p;
        logic ex;
        forever begin
            @(negedge clk);
            if (reset || !started) continue;
            if (tx) begin
                chk("done_outside_frame", {31'd0, done}, 0);
                continue;
            end
            mon_busy = 1'b1;
            if (sb_q.size() == 0) begin
                chk("unexpected_frame", 1, 0);
                e = '0;
            end else begin
                e = sb_q.pop_front();
            end
            abort = 1'b0;
            for (int k = 0; k < FL; k++) begin
                if (k > 0) begin
                    @(negedge clk);
                    if (reset) begin abort = 1'b1; break; end
                end
                p = k / BP;
                if (p == 0)                   ex = 1'b0;
                else if (p <= DB)             ex = e.d[p-1];
                else if (PB == 1 && p == DB+1) ex = ^e.d;
                else                          ex = 1'b1;
                chk("tx_bit", {31'd0, tx}, {31'd0, ex});
                chk("frame_done", {31'd0, done}, (k == FL - 1) ? 1 : 0);
                chk("busy_in_frame", {31'd0, busy}, 1);
                chk("grant", {31'd0, grant}, {31'd0, e.g});
            end
            if (!abort) begin
                @(negedge clk);
                if (!reset) begin
                    chk("idle_busy", {31'd0, busy}, 0);
                    chk("idle_tx", {31'd0, tx}, 1);
                end
            end
            mon_busy = 1'b0;
        end
    end

    task automatic wait_ready(input int ch, output int t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((ch == 0 && r0) || (ch == 1 && r1)) begin t = cyc; return; end
        end
        chk("ready_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !mon_busy && !busy) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    // Hold both valid and expect alternating grants starting with requester 0
    task automatic arb_run(input int n);
        int got = 0;
        v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 100 * n && got < n; i++) begin
            @(negedge clk);
            if (r0 || r1) begin
                chk("arb_order", {31'd0, r1}, got % 2);
                got++;
            end
        end
        if (got < n) chk("arb_timeout", got, n);
        step();
        v0 = 1'b0; v1 = 1'b0;
    endtask

    initial begin : stim
        int t, t2;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_grant", {31'd0, grant}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_ready", {30'd0, r1, r0}, 0);
        started = 1'b1;

        // Single frame, latency and end-of-frame timing
        step();
        sb_q.push_back('{g: 1'b0, d: 8'h55});
        v0 = 1'b1; d0 = 8'h55;
        wait_ready(0, t);
        step();
        v0 = 1'b0; d0 = 8'($urandom);
        @(negedge clk);
        chk("start_latency_tx", {31'd0, tx}, 0);
        repeat (39) @(negedge clk);
        chk("done_at_T40", {31'd0, done}, 1);
        @(negedge clk);
        chk("busy_at_T41", {31'd0, busy}, 0);
        chk("grant_at_T41", {31'd0, grant}, 0);
        wait_idle();

        // Back-to-back from requester 0
        step();
        sb_q.push_back('{g: 1'b0, d: 8'hFF});
        sb_q.push_back('{g: 1'b0, d: 8'h00});
        v0 = 1'b1; d0 = 8'hFF;
        wait_ready(0, t);
        step();
        d0 = 8'h00;
        wait_ready(0, t2);
        chk("b2b_gap", t2 - t, 41);
        step();
        v0 = 1'b0;
        wait_idle();

        // Round robin from a fresh reset
        reset = 1'b1; step(); reset = 1'b0;
        sb_q.push_back('{g: 1'b0, d: 8'hA3});
        sb_q.push_back('{g: 1'b1, d: 8'h3C});
        sb_q.push_back('{g: 1'b0, d: 8'hA3});
        sb_q.push_back('{g: 1'b1, d: 8'h3C});
        d0 = 8'hA3; d1 = 8'h3C;
        arb_run(4);
        wait_idle();

        // Reset mid-frame after a requester-0 frame restores requester-0 priority
        step();
        sb_q.push_back('{g: 1'b0, d: 8'h5A});
        v0 = 1'b1; d0 = 8'h5A;
        wait_ready(0, t);
        step();
        v0 = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_tx", {31'd0, tx}, 1);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        step();
        sb_q.push_back('{g: 1'b0, d: 8'h12});
        sb_q.push_back('{g: 1'b1, d: 8'h07});
        d0 = 8'h12; d1 = 8'h07;
        arb_run(2);
        wait_idle();

        repeat (5) step();
        chk("queue_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
